seq_mul8: RTL and testbench

SEQ_MUL8 -- requirements
Module: seq_mul8

---
 rtl/seq_mul8_pkg.sv | 16 +
 rtl/seq_mul8_add16.sv | 38 +++
 rtl/seq_mul8.sv | 103 ++++++++++
 tb/tb_seq_mul8.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mul8_pkg.sv
// Shared types and widths for the seq_mul8 shift-add multiplier.
package seq_mul8_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OP_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mul8_add16.sv
// 16-bit ripple-carry adder built from half/full adder cells; carries the acc+mcand path.
module ha (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y;
  assign cout = x & y;
endmodule

module fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] carry;

  ha u_ha0 (.x(x[0]), .y(y[0]), .sum(sum[0]), .cout(carry[0]));

  for (genvar i = 1; i < 16; i++) begin : g_fa
    fa u_fa (.x(x[i]), .y(y[i]), .cin(carry[i-1]), .sum(sum[i]), .cout(carry[i]));
  end

  assign cout = carry[15];
endmodule

// File: rtl/seq_mul8.sv
// Sequential 8x8 unsigned shift-add multiplier with valid/ready on both sides.
// Build option SEQ_MUL8_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1.
// Operands: in_valid/in_ready; the producer holds a/b stable while in_valid is high.
// Result:   out_valid/out_ready; p is held stable while out_valid=1 and out_ready=0.
module seq_mul8
  import seq_mul8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PROD_W-1:0] p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output state_e            dbg_state_o
);

  state_e             state_q, state_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0]  mcand_q, mcand_d;
  logic [OP_W-1:0]    mplr_q, mplr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PROD_W-1:0]  add_sum;
  logic               add_cout_unused;
  logic [OP_W-1:0]    mplr_shifted;
  logic               last_run;

  add16 u_add16 (
    .x   (acc_q),
    .y   (mcand_q),
    .sum (add_sum),
    .cout(add_cout_unused)
  );

  assign mplr_shifted = mplr_q >> 1;

`ifdef SEQ_MUL8_EARLY_TERM_EN
  // Once every multiplier bit has been consumed further iterations add nothing.
  assign last_run = (cnt_q == LAST_ITER) || (mplr_shifted == '0);
`else
  assign last_run = (cnt_q == LAST_ITER);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = '0;
          mcand_d = {{(PROD_W-OP_W){1'b0}}, a};
          mplr_d  = b;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (mplr_q[0]) acc_d = add_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shifted;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_run) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
  assign in_ready    = rst_n && (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign p           = out_valid ? acc_q : '0;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_mul8.sv
// Self-checking bench for seq_mul8: directed corner cases plus randomized ops vs. an arithmetic model.
module tb_seq_mul8;
  import seq_mul8_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a, b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] p;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  state_e      dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_q[$];

  seq_mul8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .p          (p),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Number of RUN cycles the multiplier needs for multiplier operand bb.
  function automatic int exp_latency(input logic [7:0] bb);
`ifdef SEQ_MUL8_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < 8; i++) if (bb[i]) n = i + 1;
    return n;
`else
    return 8;
`endif
  endfunction

  // driver: one complete operation, entered and left just after a negedge
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input int idle_cyc,
                       input int stall_cyc, input string tag);
    int waited;
    int lat;
    logic [15:0] held;
    logic [15:0] exp_p;
    in_valid = 1'b0;
    repeat (idle_cyc) @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_ready_wait"}, 32'(waited < 50), 32'd1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(16'(ta * tb));
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      end
      if (!out_valid) begin
        a = 8'($urandom);
        b = 8'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
    end while (!out_valid && lat < 20);
    in_valid = 1'b0;
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_latency(tb)));
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check_eq({tag, "_p"}, 32'(p), 32'(exp_p));
    held = exp_p;
    repeat (stall_cyc) begin
      @(negedge clk);
      check_eq({tag, "_stall_p"}, 32'(p), 32'(held));
      check_eq({tag, "_stall_ov"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_p_zero"}, 32'(p), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_p", 32'(p), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    do_op(8'hFF, 8'hFF, 0, 0, "ff_ff");
    do_op(8'h00, 8'h00, 1, 0, "zero");
    do_op(8'h0D, 8'h03, 0, 1, "d_3");
    do_op(8'h80, 8'h80, 0, 5, "x80_stall");
    do_op(8'h01, 8'h01, 2, 0, "one");

    // reset in the middle of RUN
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_ov", 32'(out_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst_p", 32'(p), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_hold_ov", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_release_ready", 32'(in_ready), 32'd1);
    repeat (12) begin
      @(negedge clk);
      check_eq("midrst_no_stale_ov", 32'(out_valid), 32'd0);
    end
    do_op(8'h12, 8'h34, 0, 0, "after_rst");

    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 0) rb = 8'h00;
      if (i == 1) rb = 8'h80;
      do_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
